// File: rtl/gtx_park_sequencer.sv
// Parks unused GTX_DUAL tiles one at a time: reset, wait for lock and
// reset-done (with timeout/retry), then hold the tile powered down.
module gtx_park_sequencer #(
    parameter int NUM_TILES     = 4,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int MAX_RETRIES   = 3,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                   CLK_IN,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [NUM_TILES-1:0]   PLLLKDET,
    input  logic [2*NUM_TILES-1:0] RESETDONE,
    output logic [NUM_TILES-1:0]   GTXRESET,
    output logic [NUM_TILES-1:0]   PLLPOWERDOWN,
    output logic [2*NUM_TILES-1:0] POWERDOWN,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [NUM_TILES-1:0]   FAIL,
    output logic [2:0]             CUR_TILE
);

    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  RTY_MAX  = 4'(MAX_RETRIES);
    localparam logic [2:0]  TILE_LAST = 3'(NUM_TILES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT_LOCK,
        S_WAIT_DONE,
        S_PARK,
        S_SETTLE,
        S_NEXT,
        S_FIN
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [2:0]             r_tile, w_tile_nx;
    logic [15:0]            r_timer, w_timer_nx;
    logic [3:0]             r_retry, w_retry_nx;
    logic [NUM_TILES-1:0]   r_gtx, w_gtx_nx;
    logic [NUM_TILES-1:0]   r_pllpd, w_pllpd_nx;
    logic [2*NUM_TILES-1:0] r_pd, w_pd_nx;
    logic                   r_busy, w_busy_nx;
    logic                   r_done, w_done_nx;
    logic [NUM_TILES-1:0]   r_fail, w_fail_nx;

    logic [TW-1:0] w_idx;
    logic          w_lock;
    logic          w_rdone;
    logic          w_tmo;
    logic          w_can_retry;

    assign w_idx       = r_tile[TW-1:0];
    assign w_lock      = PLLLKDET[w_idx];
    assign w_rdone     = &RESETDONE[{w_idx, 1'b0} +: 2];
    assign w_tmo       = (r_timer == TMO_LAST);
    assign w_can_retry = (r_retry < RTY_MAX);

    always_comb begin
        w_state_nx = r_state;
        w_tile_nx  = r_tile;
        w_timer_nx = r_timer;
        w_retry_nx = r_retry;
        w_gtx_nx   = r_gtx;
        w_pllpd_nx = r_pllpd;
        w_pd_nx    = r_pd;
        w_busy_nx  = r_busy;
        w_done_nx  = r_done;
        w_fail_nx  = r_fail;
        unique case (r_state)
            S_IDLE: begin
                // A (re)start un-parks every tile before sequencing again
                if (START) begin
                    w_state_nx = S_RST;
                    w_tile_nx  = 3'd0;
                    w_timer_nx = 16'd0;
                    w_retry_nx = 4'd0;
                    w_gtx_nx   = '1;
                    w_pllpd_nx = '0;
                    w_pd_nx    = '0;
                    w_busy_nx  = 1'b1;
                    w_done_nx  = 1'b0;
                    w_fail_nx  = '0;
                end
            end
            S_RST: begin
                if (r_timer == RST_LAST) begin
                    w_gtx_nx[w_idx] = 1'b0;
                    w_timer_nx      = 16'd0;
                    w_state_nx      = S_WAIT_LOCK;
                end else begin
                    w_timer_nx = r_timer + 16'd1;
                end
            end
            S_WAIT_LOCK: begin
                if (w_lock) begin
                    w_timer_nx = 16'd0;
                    w_state_nx = S_WAIT_DONE;
                end else if (w_tmo) begin
                    w_timer_nx = 16'd0;
                    if (w_can_retry) begin
                        w_retry_nx      = r_retry + 4'd1;
                        w_gtx_nx[w_idx] = 1'b1;
                        w_state_nx      = S_RST;
                    end else begin
                        w_fail_nx[w_idx] = 1'b1;
                        w_state_nx       = S_PARK;
                    end
                end else begin
                    w_timer_nx = r_timer + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                if (w_rdone) begin
                    w_timer_nx = 16'd0;
                    w_state_nx = S_PARK;
                end else if (w_tmo) begin
                    w_timer_nx = 16'd0;
                    if (w_can_retry) begin
                        w_retry_nx      = r_retry + 4'd1;
                        w_gtx_nx[w_idx] = 1'b1;
                        w_state_nx      = S_RST;
                    end else begin
                        w_fail_nx[w_idx] = 1'b1;
                        w_state_nx       = S_PARK;
                    end
                end else begin
                    w_timer_nx = r_timer + 16'd1;
                end
            end
            S_PARK: begin
                w_pd_nx[{w_idx, 1'b0} +: 2] = 2'b11;
                w_pllpd_nx[w_idx]           = 1'b1;
                w_timer_nx                  = 16'd0;
                w_state_nx                  = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_timer == SET_LAST) begin
                    w_state_nx = S_NEXT;
                end else begin
                    w_timer_nx = r_timer + 16'd1;
                end
            end
            S_NEXT: begin
                w_retry_nx = 4'd0;
                w_timer_nx = 16'd0;
                if (r_tile == TILE_LAST) begin
                    w_state_nx = S_FIN;
                end else begin
                    w_tile_nx  = r_tile + 3'd1;
                    w_state_nx = S_RST;
                end
            end
            S_FIN: begin
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_tile  <= 3'd0;
            r_timer <= 16'd0;
            r_retry <= 4'd0;
            r_gtx   <= '1;
            r_pllpd <= '0;
            r_pd    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tile  <= w_tile_nx;
            r_timer <= w_timer_nx;
            r_retry <= w_retry_nx;
            r_gtx   <= w_gtx_nx;
            r_pllpd <= w_pllpd_nx;
            r_pd    <= w_pd_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_fail  <= w_fail_nx;
        end
    end

    assign GTXRESET     = r_gtx;
    assign PLLPOWERDOWN = r_pllpd;
    assign POWERDOWN    = r_pd;
    assign BUSY         = r_busy;
    assign DONE         = r_done;
    assign FAIL         = r_fail;
    assign CUR_TILE     = r_tile;

endmodule

// File: tb/tb_gtx_park_sequencer.sv
// Directed bench for gtx_park_sequencer: two instances, one with retries
// (4 tiles) and one with MAX_RETRIES=0 (2 tiles).
module tb_gtx_park_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    logic       a_rst, a_go;
    logic [3:0] a_lk;
    logic [7:0] a_rd;
    logic [3:0] a_gtx, a_pllpd, a_fail;
    logic [7:0] a_pd;
    logic       a_busy, a_done;
    logic [2:0] a_cur;

    logic       b_rst, b_go;
    logic [1:0] b_lk;
    logic [3:0] b_rd;
    logic [1:0] b_gtx, b_pllpd, b_fail;
    logic [3:0] b_pd;
    logic       b_busy, b_done;
    logic [2:0] b_cur;

    gtx_park_sequencer #(
        .NUM_TILES(4), .RST_CYCLES(16), .LOCK_TIMEOUT(100),
        .MAX_RETRIES(3), .SETTLE_CYCLES(64)
    ) u_a (
        .CLK_IN(clk), .RESET(a_rst), .START(a_go),
        .PLLLKDET(a_lk), .RESETDONE(a_rd),
        .GTXRESET(a_gtx), .PLLPOWERDOWN(a_pllpd), .POWERDOWN(a_pd),
        .BUSY(a_busy), .DONE(a_done), .FAIL(a_fail), .CUR_TILE(a_cur)
    );

    gtx_park_sequencer #(
        .NUM_TILES(2), .RST_CYCLES(16), .LOCK_TIMEOUT(100),
        .MAX_RETRIES(0), .SETTLE_CYCLES(64)
    ) u_b (
        .CLK_IN(clk), .RESET(b_rst), .START(b_go),
        .PLLLKDET(b_lk), .RESETDONE(b_rd),
        .GTXRESET(b_gtx), .PLLPOWERDOWN(b_pllpd), .POWERDOWN(b_pd),
        .BUSY(b_busy), .DONE(b_done), .FAIL(b_fail), .CUR_TILE(b_cur)
    );

    // Board model: lock/reset-done rise a set delay after GTXRESET falls
    int       a_cnt[4];
    int       a_dly[4];
    bit [3:0] a_stuck;
    int       b_cnt[2];
    bit [1:0] b_rd_stuck;

    always @(negedge clk) begin
        for (int t = 0; t < 4; t++) begin
            if (a_gtx[t] !== 1'b0) a_cnt[t] = 0;
            else if (a_cnt[t] < 1000000) a_cnt[t]++;
            a_lk[t] = !a_stuck[t] && (a_cnt[t] >= a_dly[t]);
            a_rd[2*t +: 2] = (a_cnt[t] >= 5) ? 2'b11 : 2'b00;
        end
        for (int t = 0; t < 2; t++) begin
            if (b_gtx[t] !== 1'b0) b_cnt[t] = 0;
            else if (b_cnt[t] < 1000000) b_cnt[t]++;
            b_lk[t] = (b_cnt[t] >= 5);
            b_rd[2*t +: 2] = (!b_rd_stuck[t] && b_cnt[t] >= 5) ? 2'b11 : 2'b00;
        end
    end

    // Observers: GTXRESET falls, pulse widths, park order
    logic [3:0] a_gtx_q, a_pllpd_q;
    int         a_falls[4];
    int         a_w[4];
    int         a_badw;
    int         a_order[$];
    logic [1:0] b_gtx_q;
    int         b_falls[2];

    always @(negedge clk) begin
        for (int t = 0; t < 4; t++) begin
            if (a_gtx_q[t] === 1'b1 && a_gtx[t] === 1'b0) begin
                a_falls[t]++;
                if (a_w[t] != 16) a_badw++;
                a_w[t] = 0;
            end else if (a_busy === 1'b1 && a_cur == 3'(t) && a_gtx[t] === 1'b1) begin
                a_w[t]++;
            end
            if (a_pllpd[t] === 1'b1 && a_pllpd_q[t] !== 1'b1) a_order.push_back(t);
        end
        for (int t = 0; t < 2; t++)
            if (b_gtx_q[t] === 1'b1 && b_gtx[t] === 1'b0) b_falls[t]++;
        a_gtx_q   = a_gtx;
        a_pllpd_q = a_pllpd;
        b_gtx_q   = b_gtx;
    end

    int a_s;
    int b_s;

    task automatic a_clr();
        for (int t = 0; t < 4; t++) begin
            a_falls[t] = 0;
            a_w[t]     = 0;
        end
        a_badw = 0;
        a_order.delete();
    endtask

    task automatic a_start();
        @(negedge clk);
        a_go = 1'b1;
        @(negedge clk);
        a_go = 1'b0;
        a_s  = cyc;
    endtask

    // Waits for DONE; extra START pulses are sampled at edge a_s+p+1
    task automatic a_wait(input int p1, input int p2, input int p3,
                          output int lat);
        int n;
        lat = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            n    = cyc - a_s;
            a_go = (n == p1) || (n == p2) || (n == p3);
            if (a_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        a_go = 1'b0;
    endtask

    function automatic bit order_ok();
        bit ok;
        ok = (a_order.size() == 4);
        if (ok)
            for (int i = 0; i < 4; i++)
                if (a_order[i] != i) ok = 1'b0;
        return ok;
    endfunction

    task automatic test_reset();
        a_rst = 1'b1;
        b_rst = 1'b1;
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_gtx !== 4'hF) begin
            n_fail++;
            $display("FAIL rst_gtx: got %h want %h", a_gtx, 4'hF);
        end
        n_tests++;
        if (a_pllpd !== 4'h0 || a_pd !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_pd: got %h/%h want 0/00", a_pllpd, a_pd);
        end
        n_tests++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flags: got busy %b done %b want 0 0", a_busy, a_done);
        end
        n_tests++;
        if (a_fail !== 4'h0 || a_cur !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_fail_cur: got %h/%0d want 0/0", a_fail, a_cur);
        end
        n_tests++;
        if (b_gtx !== 2'b11 || b_pd !== 4'h0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_b: got gtx %b pd %h busy %b want 11 0 0", b_gtx, b_pd, b_busy);
        end
    endtask

    task automatic test_nominal();
        int lat;
        a_clr();
        a_start();
        a_wait(-1, -1, -1, lat);
        n_tests++;
        if (lat != 353) begin
            n_fail++;
            $display("FAIL nom_latency: got %0d want 353", lat);
        end
        n_tests++;
        if (a_pd !== 8'hFF || a_pllpd !== 4'hF) begin
            n_fail++;
            $display("FAIL nom_parked: got %h/%h want FF/F", a_pd, a_pllpd);
        end
        n_tests++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_fail !== 4'h0) begin
            n_fail++;
            $display("FAIL nom_status: got done %b busy %b fail %h want 1 0 0", a_done, a_busy, a_fail);
        end
        n_tests++;
        if (!order_ok()) begin
            n_fail++;
            $display("FAIL nom_order: got %p want 0 1 2 3", a_order);
        end
        for (int t = 0; t < 4; t++) begin
            n_tests++;
            if (a_falls[t] != 1) begin
                n_fail++;
                $display("FAIL nom_pulses%0d: got %0d want 1", t, a_falls[t]);
            end
        end
        n_tests++;
        if (a_badw != 0) begin
            n_fail++;
            $display("FAIL nom_width: got %0d bad pulses want 0", a_badw);
        end
        n_tests++;
        if (a_cur !== 3'd3) begin
            n_fail++;
            $display("FAIL nom_cur: got %0d want 3", a_cur);
        end
    endtask

    task automatic test_stuck_lock();
        int lat;
        a_stuck = 4'b0100;
        a_clr();
        a_start();
        a_wait(-1, -1, -1, lat);
        n_tests++;
        if (lat != 795) begin
            n_fail++;
            $display("FAIL stuck_latency: got %0d want 795", lat);
        end
        n_tests++;
        if (a_falls[2] != 4) begin
            n_fail++;
            $display("FAIL stuck_pulses: got %0d want 4", a_falls[2]);
        end
        n_tests++;
        if (a_fail !== 4'b0100) begin
            n_fail++;
            $display("FAIL stuck_fail: got %b want 0100", a_fail);
        end
        n_tests++;
        if (a_pd !== 8'hFF || a_pllpd !== 4'hF) begin
            n_fail++;
            $display("FAIL stuck_parked: got %h/%h want FF/F", a_pd, a_pllpd);
        end
        n_tests++;
        if (a_falls[3] != 1 || a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_tile3: got pulses %0d done %b want 1 1", a_falls[3], a_done);
        end
        n_tests++;
        if (a_badw != 0) begin
            n_fail++;
            $display("FAIL stuck_width: got %0d bad pulses want 0", a_badw);
        end
        a_stuck = 4'b0000;
    endtask

    task automatic test_lock_at_timeout();
        int lat;
        a_dly[1] = 100;
        a_clr();
        a_start();
        a_wait(-1, -1, -1, lat);
        n_tests++;
        if (lat != 448) begin
            n_fail++;
            $display("FAIL edge_latency: got %0d want 448", lat);
        end
        n_tests++;
        if (a_falls[1] != 1) begin
            n_fail++;
            $display("FAIL edge_pulses: got %0d want 1", a_falls[1]);
        end
        n_tests++;
        if (a_fail !== 4'h0) begin
            n_fail++;
            $display("FAIL edge_fail: got %b want 0000", a_fail);
        end
        a_dly[1] = 5;
    endtask

    task automatic test_reset_in_settle();
        int lat;
        bit found;
        found = 1'b0;
        a_clr();
        a_start();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (a_cur === 3'd1 && a_pllpd[1] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_reach: got no settle on tile 1 want settle");
        end
        a_rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_gtx !== 4'hF || a_pllpd !== 4'h0 || a_pd !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_pins: got %h/%h/%h want F/0/00", a_gtx, a_pllpd, a_pd);
        end
        n_tests++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_fail !== 4'h0 || a_cur !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_status: got busy %b done %b fail %h cur %0d want 0 0 0 0",
                     a_busy, a_done, a_fail, a_cur);
        end
        a_rst = 1'b0;
        a_clr();
        a_start();
        n_tests++;
        if (a_cur !== 3'd0 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: got cur %0d busy %b want 0 1", a_cur, a_busy);
        end
        a_wait(-1, -1, -1, lat);
        n_tests++;
        if (lat != 353 || !order_ok()) begin
            n_fail++;
            $display("FAIL abort_rerun: got latency %0d order %p want 353 0 1 2 3", lat, a_order);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        a_clr();
        a_start();
        a_wait(100, 200, 352, lat);
        n_tests++;
        if (lat != 353) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d want 353", lat);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (a_busy !== 1'b0 || a_done !== 1'b1 || a_pd !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_fin_start: got busy %b done %b pd %h want 0 1 FF", a_busy, a_done, a_pd);
        end
        a_start();
        n_tests++;
        if (a_pd !== 8'h00 || a_pllpd !== 4'h0 || a_gtx !== 4'hF) begin
            n_fail++;
            $display("FAIL b2b_unpark: got %h/%h/%h want 00/0/F", a_pd, a_pllpd, a_gtx);
        end
        n_tests++;
        if (a_done !== 1'b0 || a_busy !== 1'b1 || a_cur !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_restart: got done %b busy %b cur %0d want 0 1 0", a_done, a_busy, a_cur);
        end
        a_wait(-1, -1, -1, lat);
        n_tests++;
        if (lat != 353 || a_pd !== 8'hFF || a_badw != 0) begin
            n_fail++;
            $display("FAIL b2b_rerun: got latency %0d pd %h badw %0d want 353 FF 0", lat, a_pd, a_badw);
        end
    endtask

    task automatic test_no_retry();
        int lat;
        int n;
        lat           = -1;
        b_rd_stuck[0] = 1'b1;
        b_falls[0]    = 0;
        b_falls[1]    = 0;
        @(negedge clk);
        b_go = 1'b1;
        @(negedge clk);
        b_go = 1'b0;
        b_s  = cyc;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            n = cyc - b_s;
            if (b_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_tests++;
        if (lat != 276) begin
            n_fail++;
            $display("FAIL nort_latency: got %0d want 276", lat);
        end
        n_tests++;
        if (b_falls[0] != 1) begin
            n_fail++;
            $display("FAIL nort_pulses: got %0d want 1", b_falls[0]);
        end
        n_tests++;
        if (b_fail !== 2'b01) begin
            n_fail++;
            $display("FAIL nort_fail: got %b want 01", b_fail);
        end
        n_tests++;
        if (b_pd !== 4'hF || b_pllpd !== 2'b11 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nort_parked: got %h/%b busy %b want F/11 0", b_pd, b_pllpd, b_busy);
        end
    endtask

    initial begin
        a_rst      = 1'b1;
        b_rst      = 1'b1;
        a_go       = 1'b0;
        b_go       = 1'b0;
        a_stuck    = 4'b0000;
        b_rd_stuck = 2'b00;
        for (int t = 0; t < 4; t++) a_dly[t] = 5;
        a_clr();
        test_reset();
        test_nominal();
        test_stuck_lock();
        test_lock_at_timeout();
        test_reset_in_settle();
        test_back_to_back();
        test_no_retry();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
